// File: rtl/if_stage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_stage_pkg : shared IF->ID record types and fetch constants
// Rev 1.0
// ---------------------------------------------------------------------------
package if_stage_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] instruction;
    logic            valid;
  } if_stage_output_t;

  typedef struct packed {
    logic            flushEn;
    logic [XLEN-1:0] flushPC;
  } flush_req_t;

  typedef struct packed {
    logic stallEn;
    logic start;
  } stall_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_buffer : small FIFO with clear and same-cycle push/pop
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_buffer #(
  parameter  int DEPTH = 2,
  parameter  int DW    = 64,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [DW-1:0] i_pushData,
  input  logic          i_pop,
  output logic [DW-1:0] o_head,
  output logic [CW-1:0] o_count
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;
  logic          w_doPop;
  logic          w_doPush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && ((r_count != CW'(DEPTH)) || w_doPop);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= ptr_inc(r_wrPtr);
      if (w_doPop)  r_rdPtr <= ptr_inc(r_rdPtr);
      r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_pushData;
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_stage : PC generation, credit-limited imem fetch, buffered IF->ID record
// Rev 1.0
// ---------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter int               WIDTH        = XLEN,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               BUF_DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  flush_req_t       flush,
  input  stall_t           stall,
  output if_stage_output_t stageOutput,
  output logic             imemReqValid,
  output logic [WIDTH-1:0] imemReqAddr,
  input  logic             imemReqReady,
  input  logic             imemRespValid,
  input  logic [WIDTH-1:0] imemRespData
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [WIDTH-1:0]   r_fetchPC;
  logic [CW-1:0]      r_inflight;
  logic [CW-1:0]      r_dropCnt;

  logic               w_fire;
  logic               w_resp;
  logic               w_flush;
  logic               w_keep;
  logic               w_bufPush;
  logic               w_bufPop;
  logic [CW-1:0]      w_bufCount;
  logic [CW-1:0]      w_aqCount;
  logic [2*WIDTH-1:0] w_bufHead;
  logic [WIDTH-1:0]   w_respAddr;
  logic [CW:0]        w_unused;

  // decode owns the bubble on stall.start; fetch only honours stallEn
  assign w_unused = {stall.start, w_aqCount};

  // Credits count every request still owed a response, including ones that will be dropped.
  assign imemReqValid = !rst && !flush.flushEn &&
                        (({1'b0, r_inflight} + {1'b0, w_bufCount}) < (CW+1)'(BUF_DEPTH));
  assign imemReqAddr  = r_fetchPC;

  assign w_fire    = clkEn && imemReqValid && imemReqReady;
  assign w_resp    = clkEn && imemRespValid;
  assign w_flush   = clkEn && flush.flushEn;
  assign w_keep    = w_resp && !flush.flushEn && (r_dropCnt == '0);
  assign w_bufPop  = clkEn && !flush.flushEn && !stall.stallEn && (w_bufCount != '0);
  assign w_bufPush = w_keep && (stall.stallEn || (w_bufCount != '0));

  fetch_buffer #(.DEPTH(BUF_DEPTH), .DW(WIDTH)) u_addrQ (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_flush),
    .i_push     (w_fire),
    .i_pushData (r_fetchPC),
    .i_pop      (w_keep),
    .o_head     (w_respAddr),
    .o_count    (w_aqCount)
  );

  fetch_buffer #(.DEPTH(BUF_DEPTH), .DW(2*WIDTH)) u_instrBuf (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_flush),
    .i_push     (w_bufPush),
    .i_pushData ({w_respAddr, imemRespData}),
    .i_pop      (w_bufPop),
    .o_head     (w_bufHead),
    .o_count    (w_bufCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPC   <= {RESET_VECTOR[WIDTH-1:2], 2'b00};
      r_inflight  <= '0;
      r_dropCnt   <= '0;
      stageOutput <= '0;
    end else if (clkEn) begin
      if (flush.flushEn) begin
        r_fetchPC         <= {flush.flushPC[WIDTH-1:2], 2'b00};
        r_inflight        <= r_inflight - CW'(w_resp);
        r_dropCnt         <= r_inflight - CW'(w_resp);
        stageOutput.valid <= 1'b0;
      end else begin
        if (w_fire) r_fetchPC <= r_fetchPC + WIDTH'(INSTR_BYTES);
        r_inflight <= r_inflight + CW'(w_fire) - CW'(w_resp);
        if (w_resp && (r_dropCnt != '0)) r_dropCnt <= r_dropCnt - CW'(1);
        if (!stall.stallEn) begin
          if (w_bufCount != '0) begin
            stageOutput <= '{PC: w_bufHead[2*WIDTH-1:WIDTH],
                             instruction: w_bufHead[WIDTH-1:0], valid: 1'b1};
          end else if (w_keep) begin
            stageOutput <= '{PC: w_respAddr, instruction: imemRespData, valid: 1'b1};
          end else begin
            stageOutput.valid <= 1'b0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_stage : directed + random fetch traffic against an in-order memory model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] RV  = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             clkEn;
  flush_req_t       flush;
  stall_t           stall;
  if_stage_output_t out;
  logic             reqValid;
  logic [31:0]      reqAddr;
  logic             reqReady;
  logic             respValid = 1'b0;
  logic [31:0]      respData  = '0;

  if_stage #(.WIDTH(32), .RESET_VECTOR(RV), .BUF_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .clkEn         (clkEn),
    .flush         (flush),
    .stall         (stall),
    .stageOutput   (out),
    .imemReqValid  (reqValid),
    .imemReqAddr   (reqAddr),
    .imemReqReady  (reqReady),
    .imemRespValid (respValid),
    .imemRespData  (respData)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_ent_t;

  mem_ent_t         mem_q[$];
  int               cyc       = 0;
  int               epoch     = 0;
  int               tb_buf    = 0;
  int               n_fire    = 0;
  int               n_deliv   = 0;
  int               mem_extra = 0;
  bit               rand_lat  = 0;
  logic [31:0]      exp_fetch = RV;
  logic [31:0]      exp_pc    = RV;
  bit               p_rst     = 1;
  bit               p_en      = 0;
  bit               p_flush   = 0;
  bit               p_stall   = 0;
  if_stage_output_t p_out     = '0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // In-order memory: presents the oldest outstanding request once its due cycle arrives.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (mem_q.size() != 0 && cyc >= mem_q[0].due) begin
      respValid = 1'b1;
      respData  = mem_q[0].addr ^ KEY;
    end else begin
      respValid = 1'b0;
      respData  = $urandom;
    end
  end

  // Reference: an epoch-tagged stream of expected PCs; stale-epoch data must never surface.
  always @(negedge clk) begin
    bit       fire;
    bit       respc;
    bit       kept;
    mem_ent_t e;
    if (p_rst) begin
      chk("rst_out", 96'(out), 96'(0));
      chk("rst_pc", 96'(reqAddr), 96'(RV));
    end else if (!p_en || (p_stall && !p_flush)) begin
      chk("hold", 96'(out), 96'(p_out));
    end else if (p_flush) begin
      chk("flush_valid", 96'(out.valid), 96'(0));
    end else begin
      chk("out_valid", 96'(out.valid), 96'(tb_buf > 0));
      if (out.valid) begin
        chk("out_pc", 96'(out.PC), 96'(exp_pc));
        chk("out_instr", 96'(out.instruction), 96'(exp_pc ^ KEY));
        exp_pc = exp_pc + 32'd4;
        tb_buf--;
        n_deliv++;
      end
    end

    fire  = clkEn && reqValid && reqReady && !rst;
    respc = clkEn && respValid && !rst && (mem_q.size() != 0);
    chk("req_valid", 96'(reqValid),
        96'(!rst && !flush.flushEn && (mem_q.size() + tb_buf < 2)));
    if (reqValid) begin
      chk("req_addr", 96'(reqAddr), 96'(exp_fetch));
      chk("req_align", 96'(reqAddr[1:0]), 96'(0));
    end

    if (rst) begin
      mem_q.delete();
      tb_buf    = 0;
      epoch++;
      exp_fetch = RV;
      exp_pc    = RV;
    end else if (clkEn) begin
      if (respc) begin
        kept = !flush.flushEn && (mem_q[0].epoch == epoch);
        void'(mem_q.pop_front());
        if (kept) tb_buf++;
      end
      if (flush.flushEn) begin
        tb_buf    = 0;
        epoch++;
        exp_fetch = flush.flushPC & ~32'h3;
        exp_pc    = exp_fetch;
      end else if (fire) begin
        e.addr  = reqAddr;
        e.epoch = epoch;
        e.due   = cyc + 1 + (rand_lat ? int'($urandom_range(0, 2)) : mem_extra);
        mem_q.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
        n_fire++;
      end
    end

    p_rst   = rst;
    p_en    = clkEn;
    p_flush = flush.flushEn;
    p_stall = stall.stallEn;
    p_out   = out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int lim);
    for (int i = 0; i < lim && !out.valid; i++) step();
    chk(tag, 96'(out.valid), 96'(1));
  endtask

  task automatic wait_full(input string tag, input int lim);
    for (int i = 0; i < lim && reqValid; i++) step();
    chk(tag, 96'(reqValid), 96'(0));
  endtask

  initial begin
    int f0;
    int d0;
    rst = 1'b1; clkEn = 1'b1; flush = '0; stall = '0; reqReady = 1'b1;
    step(); step();

    // basic streaming from the reset vector
    rst = 1'b0;
    #1;
    chk("first_addr", 96'(reqAddr), 96'(32'h0));
    chk("first_reqv", 96'(reqValid), 96'(1));
    step(); chk("c1_valid", 96'(out.valid), 96'(0));
    step(); chk("c2_pc", 96'(out.PC), 96'(32'h0)); chk("c2_valid", 96'(out.valid), 96'(1));
    step(); chk("c3_pc", 96'(out.PC), 96'(32'h4));
    step(); chk("c4_pc", 96'(out.PC), 96'(32'h8));

    // stall: output holds, credits exhaust, then drain without gap
    stall.stallEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 96'(out.PC), 96'(32'h8));
      chk("stall_reqv", 96'(reqValid), 96'(0));
    end
    stall.stallEn = 1'b0;
    step(); chk("rel_pc0", 96'(out.PC), 96'(32'hC));
    step(); chk("rel_pc1", 96'(out.PC), 96'(32'h10));
    step(); chk("rel_pc2", 96'(out.PC), 96'(32'h14));

    // flush with two slow requests outstanding
    mem_extra = 3;
    wait_full("fill_timeout", 10);
    flush = '{flushEn: 1'b1, flushPC: 32'h103};
    step();
    flush = '0;
    #1;
    chk("fl_addr", 96'(reqAddr), 96'(32'h100));
    chk("fl_valid", 96'(out.valid), 96'(0));
    mem_extra = 0;
    wait_valid("fl_timeout", 20);
    chk("fl_first_pc", 96'(out.PC), 96'(32'h100));

    // flush colliding with a stall and a live response
    step(); step();
    chk("coll_resp", 96'(respValid), 96'(1));
    stall.stallEn = 1'b1;
    flush = '{flushEn: 1'b1, flushPC: 32'h200};
    step();
    stall = '0; flush = '0;
    #1;
    chk("coll_valid", 96'(out.valid), 96'(0));
    chk("coll_addr", 96'(reqAddr), 96'(32'h200));
    wait_valid("coll_timeout", 20);
    chk("coll_pc", 96'(out.PC), 96'(32'h200));

    // PC wrap
    flush = '{flushEn: 1'b1, flushPC: 32'hFFFF_FFF8};
    step();
    flush = '0;
    wait_valid("wrap_timeout", 20);
    chk("wrap_pc0", 96'(out.PC), 96'(32'hFFFF_FFF8));
    step(); chk("wrap_pc1", 96'(out.PC), 96'(32'hFFFF_FFFC));
    step(); chk("wrap_pc2", 96'(out.PC), 96'(32'h0));

    // clock enable alternating
    rst = 1'b1; step(); step();
    rst = 1'b0;
    f0 = n_fire; d0 = n_deliv;
    for (int i = 0; i < 16; i++) begin
      clkEn = (i % 2 == 0);
      step();
    end
    clkEn = 1'b1;
    chk("ce_fires", 96'(n_fire - f0), 96'(8));
    chk("ce_deliv", 96'(n_deliv - d0), 96'(7));
    chk("ce_last_pc", 96'(out.PC), 96'(32'h18));

    // reset mid-stream with requests in flight
    mem_extra = 3;
    wait_full("rst_fill_timeout", 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_out", 96'(out), 96'(0));
    chk("mid_rst_addr", 96'(reqAddr), 96'(RV));
    chk("mid_rst_credit", 96'(reqValid), 96'(1));
    mem_extra = 0;

    // randomized traffic
    rand_lat = 1;
    for (int i = 0; i < 500; i++) begin
      reqReady      = ($urandom_range(0, 3) != 0);
      clkEn         = ($urandom_range(0, 4) != 0);
      stall.stallEn = ($urandom_range(0, 4) == 0);
      stall.start   = 1'($urandom);
      flush.flushEn = ($urandom_range(0, 19) == 0);
      flush.flushPC = $urandom;
      rst           = ($urandom_range(0, 99) == 0);
      step();
    end
    rand_lat = 0;
    rst = 1'b0; clkEn = 1'b1; stall = '0; flush = '0; reqReady = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("final_stream", 96'(out.valid), 96'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
